// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the handshaked data-memory responder:
//   - state_e  : responder FSM states (IDLE, WAIT, RESP)
//   - DATA_W / ADDR_W / STRB_W : bus widths
//   - addr_err : access-error rule (misaligned or beyond the backing array)
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int STRB_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access is bad when it is not on a 64-bit word boundary or when its word
  // number lies past the last word of the array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       depth);
    logic [ADDR_W-4:0] word_num;
    word_num = addr[ADDR_W-1:3];
    return (addr[2:0] != 3'd0) || (word_num >= (ADDR_W-3)'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response channel between the memory-stage initiator (master) and the
// data-memory responder (slave).
//   req_valid/req_ready           : request handshake
//   req_write/req_addr/req_wdata  : request payload (store flag, byte address, data)
//   req_wstrb                     : byte strobes, present only with DMEM_BYTE_STRB_EN
//   resp_valid/resp_ready         : response handshake
//   resp_rdata/resp_err           : load data and access-error flag
// Optional feature macro: DMEM_BYTE_STRB_EN
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef DMEM_BYTE_STRB_EN
  logic [STRB_W-1:0] req_wstrb;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
`ifdef DMEM_BYTE_STRB_EN
    output req_wstrb,
`endif
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
`ifdef DMEM_BYTE_STRB_EN
    input  req_wstrb,
`endif
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-organised backing store: synchronous write with a per-byte lane mask,
// combinational read of the same word.
//   clk   : write clock
//   we    : write enable for this edge
//   idx   : word index for both read and write
//   wmask : byte-lane enables (bit i covers data bits 8i+7:8i)
//   wdata : store data
//   rdata : current contents of word idx
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [STRB_W-1:0] wmask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array is deliberately not reset: contents survive a responder
  // reset, and a reset loop over every word would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Request/response data memory for the multi-cycle LEGv8 datapath. A request is
// accepted in IDLE, waits WAIT_CYCLES cycles, performs the array access on the
// last wait edge, then holds the response in RESP until the initiator takes it.
//   clk    : clock, all state updates on the rising edge
//   resetl : synchronous, active-high reset (array contents retained)
//   bus    : slave side of data_mem_responder_if
//   busy   : high whenever the FSM is not in IDLE
// Parameters: DEPTH (words, power of two >= 2), WAIT_CYCLES (0..15)
// Optional feature macro: DMEM_BYTE_STRB_EN (per-byte store strobes)
// -----------------------------------------------------------------------------
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 resetl,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  // Control state (reset)
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // Latched request (datapath, no reset)
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              in_idle;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [STRB_W-1:0] acc_strb;
  logic              acc_err;
  logic              do_access;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] acc_rdata;

  assign in_idle = (state_q == IDLE);

  // With no wait states the access happens on the accepting edge itself, so it
  // must see the live request; otherwise it uses the copy latched at accept.
  assign acc_write = in_idle ? bus.req_write : write_q;
  assign acc_addr  = in_idle ? bus.req_addr  : addr_q;
  assign acc_wdata = in_idle ? bus.req_wdata : wdata_q;

`ifdef DMEM_BYTE_STRB_EN
  logic [STRB_W-1:0] strb_q, strb_d;
  assign acc_strb = in_idle ? bus.req_wstrb : strb_q;
`else
  assign acc_strb = '1;
`endif

  assign acc_err   = addr_err(acc_addr, DEPTH);
  assign do_access = (in_idle && bus.req_valid && ZERO_WAIT) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));
  // A reset on the access edge drops the transaction, including its store.
  assign mem_we    = do_access && acc_write && !acc_err && !resetl;
  assign acc_rdata = (acc_write || acc_err) ? '0 : mem_rdata;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (acc_addr[3 +: IDX_W]),
    .wmask (acc_strb),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef DMEM_BYTE_STRB_EN
    strb_d  = strb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef DMEM_BYTE_STRB_EN
          strb_d  = bus.req_wstrb;
`endif
          if (ZERO_WAIT) begin
            state_d = RESP;
            rdata_d = acc_rdata;
            err_d   = acc_err;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = acc_rdata;
          err_d   = acc_err;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (resetl) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request payload is only consumed after it has been latched, so it needs no reset.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
`ifdef DMEM_BYTE_STRB_EN
    strb_q  <= strb_d;
`endif
  end

  assign bus.req_ready  = in_idle;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = !in_idle;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Handshaked data-memory responder that serves 64-bit load/store requests from a multi-cycle LEGv8 datapath. It replaces the zero-latency data memory with a request/response slave that has configurable wait states. Requests are accepted on a valid/ready handshake, and results return on a separate response channel. It sits between the processor's memory-stage initiator and the word-organised backing array.

Parameters:
DEPTH, 64, number of 64-bit words in the backing array (power of two, >=2)
WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15)

Ports:
clk  in  1  clock, all state updates on rising edge
resetl  in  1  reset, synchronous, active-high
req_valid  in  1  initiator presents a request
req_ready  out  1  responder can accept a request
req_write  in  1  1=store, 0=load
req_addr  in  64  byte address
req_wdata  in  64  store data
resp_valid  out  1  response available
resp_ready  in  1  initiator accepts the response
resp_rdata  out  64  load data; 0 for stores and errors
resp_err  out  1  misaligned or out-of-range access
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (resetl=1 at a rising edge):
  - state goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Array contents are retained.
  - A request in flight is dropped; a pending store is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch write/addr/wdata.
  - If WAIT_CYCLES>0, load counter=WAIT_CYCLES and go to WAIT; otherwise perform the access and go to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each edge.
  - When counter==1 at an edge, perform the access and go to RESP.
- RESP:
  - req_ready=0, resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_ready=1 at an edge; then go to IDLE.
  - No same-cycle re-accept: req_ready rises the cycle after the response completes.
- Latency: resp_valid asserts exactly WAIT_CYCLES+1 cycles after the accepting edge.
- Maximum throughput: one transaction per WAIT_CYCLES+2 cycles when resp_ready is held high.
- Access rules:
  - word index = req_addr[3+log2(DEPTH)-1:3].
  - Error if req_addr[2:0]!=0 or req_addr[63:3]>=DEPTH. On error: no write, rdata=0, err=1.
  - Load: rdata = mem[index].
  - Store: mem[index] <= wdata and rdata=0.
  - The write commits on the access edge, not at the response handshake.
- Request inputs are ignored whenever req_ready=0; they do not need to be stable.
- A load after a store to the same address returns the new data; no forwarding is needed because transactions are serialised.

Optional Feature:
- Macro DMEM_BYTE_STRB_EN.
- Defined:
  - Adds input req_wstrb[7:0], latched at acceptance.
  - A store updates only the bytes whose strobe bit is 1 (bit i covers bits 8i+7:8i).
  - A store with strobe 0x00 is legal and is a no-op write.
  - The alignment check is unchanged.
- Undefined: the port is absent and stores write the full 64-bit word.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - DATA_W=64, ADDR_W=64, STRB_W=8
  - a function computing the error flag from address and DEPTH
- One sub-module, dmem_array: synchronous-write, combinational-read word array with a byte-lane write mask. Without DMEM_BYTE_STRB_EN the mask is tied to all ones.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then store 0xDEAD_BEEF_0123_4567 to addr 0x10, then load 0x10 (WAIT_CYCLES=2) -> resp_valid 3 cycles after each accept; load rdata=0xDEADBEEF01234567, err=0.
- Load at addr 0x13 (misaligned) and at addr 8*DEPTH (out of range) -> err=1, rdata=0; the preceding store to 0x10 is unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stay stable; req_ready=0; a req_valid pulse in that window is ignored.
- Assert resetl during WAIT of a store to 0x20 -> outputs return to reset values the next cycle; a later load of 0x20 returns the prior contents.
- WAIT_CYCLES=0, back-to-back requests with resp_ready=1 -> each response 1 cycle after accept; one transaction per 2 cycles.
- DMEM_BYTE_STRB_EN: after 0xFFFF_FFFF_FFFF_FFFF is stored at 0x08, store 0x0 with strb=0x0F -> load returns 0xFFFFFFFF00000000.
